// File: rtl/wb_reg_file_pkg.sv
// wb_reg_file_pkg: widths, index/word types and dump FSM states for wb_reg_file
package wb_reg_file_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef enum logic [1:0] {IDLE = 2'd0, DUMP = 2'd1, DONE = 2'd2} rf_state_t;
  localparam reg_idx_t LAST_IDX = reg_idx_t'(NUM_REGS - 1);
endpackage

// File: rtl/wb_reg_file_if.sv
// wb_reg_file_if: read ports, write-back stream, halt and dump/halted outputs; master drives, slave is the register file
interface wb_reg_file_if;
  import wb_reg_file_pkg::*;
  reg_idx_t p0_addr, p1_addr, dst_addr, dump_addr;
  word_t p0, p1, dst, dump_data;
  logic we, hlt, dump_valid, halted;
  modport master (
    output p0_addr, p1_addr, we, dst_addr, dst, hlt,
    input  p0, p1, dump_valid, dump_addr, dump_data, halted
  );
  modport slave (
    input  p0_addr, p1_addr, we, dst_addr, dst, hlt,
    output p0, p1, dump_valid, dump_addr, dump_data, halted
  );
endinterface

// File: rtl/wb_reg_file.sv
// wb_reg_file: 16x16 register file (R0=0) with write bypass and a post-HALT sequential dump; ports clk, rst_n, bus (slave)
module wb_reg_file
  import wb_reg_file_pkg::*;
(
  input logic clk,
  input logic rst_n,
  wb_reg_file_if.slave bus
);
  word_t rf_q [NUM_REGS];
  word_t rf_d [NUM_REGS];
  rf_state_t state_q, state_d;
  reg_idx_t idx_q, idx_d;
  logic wr;
  always_comb begin
    wr = state_q == IDLE && bus.we && bus.dst_addr != '0;
    rf_d = rf_q;
    if (wr) rf_d[bus.dst_addr] = bus.dst;
    state_d = state_q == IDLE ? (bus.hlt ? DUMP : IDLE)
            : state_q == DUMP ? (idx_q == LAST_IDX ? DONE : DUMP) : DONE;
    idx_d = state_q == IDLE ? (bus.hlt ? reg_idx_t'(1) : '0)
          : state_q == DUMP ? idx_q + reg_idx_t'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_q <= '{default: '0};
      state_q <= IDLE;
      idx_q <= '0;
    end else begin
      rf_q <= rf_d;
      state_q <= state_d;
      idx_q <= idx_d;
    end
  end
  assign bus.p0 = wr && bus.p0_addr == bus.dst_addr ? bus.dst : rf_q[bus.p0_addr];
  assign bus.p1 = wr && bus.p1_addr == bus.dst_addr ? bus.dst : rf_q[bus.p1_addr];
  assign bus.dump_valid = state_q == DUMP;
  assign bus.dump_addr = state_q == DUMP ? idx_q : '0;
  assign bus.dump_data = state_q == DUMP ? rf_q[idx_q] : '0;
  assign bus.halted = state_q == DONE;
endmodule

// File: tb/tb_wb_reg_file.sv
// tb_wb_reg_file: randomized self-checking bench for wb_reg_file against a behavioural model
module tb_wb_reg_file;
  logic clk = 0;
  logic rst_n = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] m [16];
  bit in_dump = 0;
  bit m_halted = 0;
  int dpos = 0;
  wb_reg_file_if bus ();
  wb_reg_file dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_p(input logic [3:0] a);
    if (!in_dump && !m_halted && bus.we && bus.dst_addr != 0 && a == bus.dst_addr) return bus.dst;
    return m[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      foreach (m[i]) m[i] = '0;
      in_dump = 0;
      m_halted = 0;
      dpos = 0;
    end else if (in_dump) begin
      if (dpos == 15) begin in_dump = 0; m_halted = 1; end
      else dpos++;
    end else if (!m_halted) begin
      if (bus.we && bus.dst_addr != 0) m[bus.dst_addr] = bus.dst;
      if (bus.hlt) begin in_dump = 1; dpos = 1; end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.we = 0; bus.hlt = 0; bus.dst_addr = 0; bus.dst = 0; bus.p0_addr = 0; bus.p1_addr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    bus.p0_addr = 5; bus.p1_addr = 15;
    @(negedge clk);
    n_tests += 4;
    if (bus.p0 !== 16'h0) begin n_fail++; $display("FAIL reset_p0 got %h exp 0000", bus.p0); end
    if (bus.p1 !== 16'h0) begin n_fail++; $display("FAIL reset_p1 got %h exp 0000", bus.p1); end
    if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", bus.halted); end
    if (bus.dump_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dump_valid got %b exp 0", bus.dump_valid); end
  endtask

  task automatic test_write_read();
    bus.we = 1; bus.dst_addr = 3; bus.dst = 16'hBEEF;
    tick();
    bus.we = 0; bus.p0_addr = 3;
    @(negedge clk);
    n_tests++;
    if (bus.p0 !== 16'hBEEF) begin n_fail++; $display("FAIL write_read got %h exp beef", bus.p0); end
  endtask

  task automatic test_bypass();
    bus.we = 1; bus.dst_addr = 7; bus.dst = 16'h1234; bus.p0_addr = 7; bus.p1_addr = 7;
    @(negedge clk);
    n_tests += 2;
    if (bus.p0 !== 16'h1234) begin n_fail++; $display("FAIL bypass_p0 got %h exp 1234", bus.p0); end
    if (bus.p1 !== 16'h1234) begin n_fail++; $display("FAIL bypass_p1 got %h exp 1234", bus.p1); end
    tick();
    for (int i = 0; i < 40; i++) begin
      bus.we = 1'($urandom_range(0, 1));
      bus.dst_addr = 4'($urandom);
      bus.dst = 16'($urandom);
      bus.p0_addr = ($urandom_range(0, 2) == 0) ? bus.dst_addr : 4'($urandom);
      bus.p1_addr = ($urandom_range(0, 2) == 0) ? bus.dst_addr : 4'($urandom);
      @(negedge clk);
      n_tests += 2;
      if (bus.p0 !== exp_p(bus.p0_addr)) begin n_fail++; $display("FAIL rand_p0 addr %0d got %h exp %h", bus.p0_addr, bus.p0, exp_p(bus.p0_addr)); end
      if (bus.p1 !== exp_p(bus.p1_addr)) begin n_fail++; $display("FAIL rand_p1 addr %0d got %h exp %h", bus.p1_addr, bus.p1, exp_p(bus.p1_addr)); end
      tick();
    end
  endtask

  task automatic test_r0();
    bus.we = 1; bus.dst_addr = 0; bus.dst = 16'hFFFF; bus.p0_addr = 0;
    @(negedge clk);
    n_tests++;
    if (bus.p0 !== 16'h0) begin n_fail++; $display("FAIL r0_same_cycle got %h exp 0000", bus.p0); end
    tick();
    bus.we = 0;
    @(negedge clk);
    n_tests++;
    if (bus.p0 !== 16'h0) begin n_fail++; $display("FAIL r0_next_cycle got %h exp 0000", bus.p0); end
  endtask

  task automatic test_halt_dump();
    for (int r = 1; r < 16; r++) begin
      bus.we = 1; bus.dst_addr = 4'(r); bus.dst = 16'h0100 + 16'(r);
      tick();
    end
    bus.hlt = 1; bus.we = 1; bus.dst_addr = 15; bus.dst = 16'hAAAA;
    tick();
    for (int k = 1; k < 16; k++) begin
      bus.hlt = 1'($urandom_range(0, 1));
      bus.we = 1; bus.dst_addr = 2; bus.dst = 16'h5555; bus.p0_addr = 2;
      @(negedge clk);
      n_tests += 4;
      if (bus.dump_valid !== 1'b1) begin n_fail++; $display("FAIL dump_valid k=%0d got %b exp 1", k, bus.dump_valid); end
      if (bus.dump_addr !== 4'(k)) begin n_fail++; $display("FAIL dump_addr got %0d exp %0d", bus.dump_addr, k); end
      if (bus.dump_data !== (k < 15 ? 16'h0100 + 16'(k) : 16'hAAAA)) begin n_fail++; $display("FAIL dump_data k=%0d got %h exp %h", k, bus.dump_data, (k < 15 ? 16'h0100 + 16'(k) : 16'hAAAA)); end
      if (bus.p0 !== 16'h0102) begin n_fail++; $display("FAIL dump_lockout_p0 got %h exp 0102", bus.p0); end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      bus.hlt = 1;
      @(negedge clk);
      n_tests += 4;
      if (bus.dump_valid !== 1'b0) begin n_fail++; $display("FAIL done_dump_valid got %b exp 0", bus.dump_valid); end
      if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL done_halted got %b exp 1", bus.halted); end
      if (bus.dump_addr !== 4'h0 || bus.dump_data !== 16'h0) begin n_fail++; $display("FAIL done_dump_zero got %h/%h exp 0/0000", bus.dump_addr, bus.dump_data); end
      if (bus.p0 !== exp_p(2)) begin n_fail++; $display("FAIL done_read got %h exp %h", bus.p0, exp_p(2)); end
      tick();
    end
  endtask

  task automatic test_reset_mid_dump();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    bus.we = 1; bus.dst_addr = 4; bus.dst = 16'($urandom) | 16'h1;
    tick();
    bus.we = 0; bus.hlt = 1;
    tick();
    bus.hlt = 0;
    repeat (4) tick();
    rst_n = 0; bus.we = 1; bus.hlt = 1; bus.dst_addr = 4; bus.dst = 16'h7777;
    tick();
    rst_n = 1; bus.we = 0; bus.hlt = 0; bus.p0_addr = 4;
    @(negedge clk);
    n_tests += 3;
    if (bus.dump_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dump_valid got %b exp 0", bus.dump_valid); end
    if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL rst_mid_halted got %b exp 0", bus.halted); end
    if (bus.p0 !== 16'h0) begin n_fail++; $display("FAIL rst_mid_r4 got %h exp 0000", bus.p0); end
    bus.hlt = 1;
    tick();
    bus.hlt = 0;
    @(negedge clk);
    n_tests += 2;
    if (bus.dump_valid !== 1'b1) begin n_fail++; $display("FAIL restart_valid got %b exp 1", bus.dump_valid); end
    if (bus.dump_addr !== 4'd1) begin n_fail++; $display("FAIL restart_addr got %0d exp 1", bus.dump_addr); end
    for (int c = 0; c < 40 && bus.halted !== 1'b1; c++) tick();
    n_tests++;
    if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL restart_halted timeout got %b exp 1", bus.halted); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_halt_dump();
    test_reset_mid_dump();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
